decoder_scan_seq: RTL and testbench

- Parametrised, registered N-to-OUTS one-hot decoder; next generation of the combinational 4-to-16 decoder with enable.
- Adds a clocked auto-scan mode: an internal index steps through every output with a programmable dwell time.
- Drives digit/row selects for multiplexed displays and keypads, and registered chip-select fan-out in lab designs.

---
 rtl/decoder_scan_seq.sv | 93 +++++++++
 tb/tb_decoder_scan_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq.sv
// Registered N-to-OUTS one-hot decoder with a clocked auto-scan mode.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   en   - enable; low forces y inactive and freezes the scan state
//   mode - 0 = direct decode of a, 1 = auto-scan
//   a    - address decoded in direct mode
//   y    - registered one-hot select
//   idx  - registered index of the active output
//   wrap - one-cycle pulse when the scan index wraps to 0
// Build option: DECODER_SCAN_ACTIVE_LOW_EN makes y active-low (idle all ones).
module decoder_scan_seq #(
    parameter int N     = 4,
    parameter int OUTS  = 16,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    a,
    output logic [OUTS-1:0] y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [N:0]      OUTS_W   = (N+1)'(OUTS);
    localparam logic [N-1:0]    IDX_LAST = N'(OUTS - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [OUTS-1:0] ONE      = OUTS'(1);

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [N-1:0]    idx_n;
    logic            wrap_n;
    logic [OUTS-1:0] sel_n;

    always_comb begin
        cnt_n  = cnt;
        idx_n  = idx;
        wrap_n = 1'b0;
        sel_n  = '0;
        if (en) begin
            if (!mode) begin
                cnt_n = '0;
                // Out-of-range addresses select nothing and keep idx.
                if ({1'b0, a} < OUTS_W) begin
                    idx_n = a;
                    sel_n = ONE << a;
                end
            end else begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx == IDX_LAST) begin
                        idx_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        idx_n = idx + N'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                // Decode the next index so y and idx change together.
                sel_n = ONE << idx_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= '0;
            wrap <= 1'b0;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
            y    <= '1;
`else
            y    <= '0;
`endif
        end else begin
            cnt  <= cnt_n;
            idx  <= idx_n;
            wrap <= wrap_n;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
            y    <= ~sel_n;
`else
            y    <= sel_n;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Testbench for decoder_scan_seq: direct-decode vector table plus
// hand-written scan, wrap, freeze/resume and partial-decode sequences.
module tb_decoder_scan_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [3:0]  a;
    logic [15:0] y16;
    logic [3:0]  idx16;
    logic        wrap16;
    logic [9:0]  y10;
    logic [3:0]  idx10;
    logic        wrap10;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_scan_seq #(.N(4), .OUTS(16), .DWELL(4)) u16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a),
        .y(y16), .idx(idx16), .wrap(wrap16)
    );

    decoder_scan_seq #(.N(4), .OUTS(10), .DWELL(4)) u10 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a),
        .y(y10), .idx(idx10), .wrap(wrap10)
    );

    typedef struct {
        logic        en;
        logic        mode;
        logic [3:0]  a;
        logic [15:0] y;
        logic [3:0]  idx;
        logic        wrap;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [15:0] ex16(input logic [15:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] ex10(input logic [9:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        return {6'b0, ~v};
`else
        return {6'b0, v};
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] one;
        one = 16'h0001;
        rst = 1'b1; en = 1'b1; mode = 1'b1; a = 4'd0;

        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b0, 4'(i), one << i, 4'(i), 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'd3,  16'h0000, 4'd15, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 4'd9,  16'h0000, 4'd15, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'd0,  16'h0000, 4'd15, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 4'd7,  16'h0080, 4'd7,  1'b0};

        // Reset held with en=1, mode=1.
        step();
        chk("rst1_y", y16, ex16(16'h0000));
        chk("rst1_idx", {12'b0, idx16}, 16'd0);
        step();
        chk("rst2_y", y16, ex16(16'h0000));
        chk("rst2_idx", {12'b0, idx16}, 16'd0);
        chk("rst2_wrap", {15'b0, wrap16}, 16'd0);
        rst = 1'b0;

        // Full scan from reset: idx = k/4 after edge k, wrap at k=64.
        for (int k = 1; k <= 70; k++) begin
            logic [3:0] ei;
            step();
            ei = 4'((k / 4) % 16);
            chk($sformatf("scan_idx_k%0d", k), {12'b0, idx16}, {12'b0, ei});
            chk($sformatf("scan_y_k%0d", k), y16, ex16(one << ei));
            chk($sformatf("scan_wrap_k%0d", k), {15'b0, wrap16},
                (k == 64) ? 16'd1 : 16'd0);
        end

        // Direct-decode table.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; a = tbl[i].a;
            step();
            chk($sformatf("tbl%0d_y", i), y16, ex16(tbl[i].y));
            chk($sformatf("tbl%0d_idx", i), {12'b0, idx16}, {12'b0, tbl[i].idx});
            chk($sformatf("tbl%0d_wrap", i), {15'b0, wrap16}, {15'b0, tbl[i].wrap});
        end

        // Freeze/resume: scan to idx 5 with one dwell cycle used.
        en = 1'b1; mode = 1'b1;
        do_reset();
        repeat (21) step();
        chk("frz_pre_idx", {12'b0, idx16}, 16'd5);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("frz_y%0d", k), y16, ex16(16'h0000));
            chk($sformatf("frz_idx%0d", k), {12'b0, idx16}, 16'd5);
            chk($sformatf("frz_wrap%0d", k), {15'b0, wrap16}, 16'd0);
        end
        en = 1'b1;
        step();
        chk("res1_y", y16, ex16(16'h0020));
        chk("res1_wrap", {15'b0, wrap16}, 16'd0);
        step();
        chk("res2_idx", {12'b0, idx16}, 16'd5);
        step();
        chk("res3_idx", {12'b0, idx16}, 16'd6);
        chk("res3_y", y16, ex16(16'h0040));

        // Scan to direct: decode takes effect on the next edge.
        mode = 1'b0; a = 4'd2;
        step();
        chk("m10_y", y16, ex16(16'h0004));
        chk("m10_idx", {12'b0, idx16}, 16'd2);

        // Partial decode on the OUTS=10 instance.
        do_reset();
        mode = 1'b0; a = 4'd7;
        step();
        chk("p_a7_y", {6'b0, y10}, ex10(10'h080));
        chk("p_a7_idx", {12'b0, idx10}, 16'd7);
        a = 4'd12;
        step();
        chk("p_a12_y", {6'b0, y10}, ex10(10'h000));
        chk("p_a12_idx", {12'b0, idx10}, 16'd7);
        mode = 1'b1;
        step();
        chk("p_s1_y", {6'b0, y10}, ex10(10'h080));
        chk("p_s1_idx", {12'b0, idx10}, 16'd7);
        repeat (3) step();
        chk("p_s4_idx", {12'b0, idx10}, 16'd8);
        repeat (4) step();
        chk("p_s8_idx", {12'b0, idx10}, 16'd9);
        chk("p_s8_y", {6'b0, y10}, ex10(10'h200));
        repeat (3) step();
        chk("p_s11_wrap", {15'b0, wrap10}, 16'd0);
        step();
        chk("p_s12_idx", {12'b0, idx10}, 16'd0);
        chk("p_s12_wrap", {15'b0, wrap10}, 16'd1);
        chk("p_s12_y", {6'b0, y10}, ex10(10'h001));
        step();
        chk("p_s13_wrap", {15'b0, wrap10}, 16'd0);

        // Reset mid-scan, then resume scanning from output 0.
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("mrst_y", y16, ex16(16'h0000));
        chk("mrst_idx", {12'b0, idx16}, 16'd0);
        rst = 1'b0;
        step();
        chk("mrst_rel_y", y16, ex16(16'h0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
